// File: rtl/hdcp_seq_pkg.sv
// hdcp_seq_pkg
//   Shared definitions for the HDCP sink link sequencer: one-hot state
//   encoding, the per-frame CTL encryption codes, the DDC offset where the
//   latched Ri value is published, and a small state-class helper.
package hdcp_seq_pkg;

    typedef enum logic [5:0] {
        S_IDLE       = 6'b000001,
        S_AUTH_BUSY  = 6'b000010,
        S_AUTH_DONE  = 6'b000100,
        S_RUN        = 6'b001000,
        S_FRAME_BUSY = 6'b010000,
        S_FAULT      = 6'b100000
    } state_e;

    localparam logic [3:0] CTL_ENC_EN    = 4'b1001;
    localparam logic [3:0] CTL_ENC_DIS   = 4'b0001;
    localparam logic [7:0] RI_DDC_OFFSET = 8'h08;

    // States in which the cipher is expected to drop and re-raise ready.
    function automatic logic is_busy(state_e s);
        return (s == S_AUTH_BUSY) || (s == S_FRAME_BUSY);
    endfunction

endpackage

// File: rtl/hdcp_stall_timer.sv
// hdcp_stall_timer
//   Saturating cycle counter used to detect a cipher that never re-raises
//   stream_ready. Clear has priority over enable; the count stops at
//   TIMEOUT_CYC and tc_o stays high until cleared.
// Ports:
//   clk, rst  - clock, async active-high reset
//   en_i      - count this cycle
//   clr_i     - synchronous clear
//   tc_o      - count has reached TIMEOUT_CYC
module hdcp_stall_timer #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);
    localparam int             CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TERM = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != TERM))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/hdcp_link_sequencer.sv
// hdcp_link_sequencer
//   Sink-side frame-level controller beside the HDCP cipher. Tracks
//   authentication, counts frame-key events, snapshots Ri at authentication
//   and every RI_PERIOD frames, decodes ENC_EN/ENC_DIS per frame and flags
//   cipher stalls as a sticky link fault.
// Ports:
//   clk, rst      - pixel clock, async active-high reset
//   hpd           - high = no cable, synchronous clear to idle
//   auth_start    - Aksv written strobe, (re)starts authentication
//   frame_init    - per-frame cipher re-init strobe
//   stream_ready  - cipher ready
//   vsync         - vertical sync, active high
//   ctl_code      - decoded CTL3..CTL0
//   ri_in         - cipher Ri output
//   ri_out        - latched Ri for the DDC register block
//   ri_update     - one-cycle strobe when ri_out is reloaded
//   frame_cnt     - frames since authentication, mod RI_PERIOD
//   enc_frame     - current frame is encrypted
//   authed        - authentication complete, link running
//   link_fault    - sticky stall fault
module hdcp_link_sequencer
    import hdcp_seq_pkg::*;
#(
    parameter int RI_PERIOD   = 128,
    parameter int TIMEOUT_CYC = 4096,
    parameter int FCW         = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           hpd,
    input  logic           auth_start,
    input  logic           frame_init,
    input  logic           stream_ready,
    input  logic           vsync,
    input  logic [3:0]     ctl_code,
    input  logic [15:0]    ri_in,
    output logic [15:0]    ri_out,
    output logic           ri_update,
    output logic [FCW-1:0] frame_cnt,
    output logic           enc_frame,
    output logic           authed,
    output logic           link_fault
);
    localparam logic [FCW-1:0] CNT_LAST = FCW'(RI_PERIOD - 1);

    state_e         state_q;
    logic [15:0]    ri_out_q;
    logic           ri_update_q;
    logic [FCW-1:0] frame_cnt_q;
    logic           enc_frame_q;
    logic           authed_q;
    logic           link_fault_q;
    logic           low_seen_q;   // ready has dropped since entering a busy state
    logic           pending_q;    // encryption decision for the frame being signalled
    logic           vsync_q;

    logic stall_en, stall_clr, stall_tc;
    logic vsync_fall;

    assign stall_en   = is_busy(state_q) && !stream_ready;
    assign stall_clr  = hpd || auth_start || stream_ready || !is_busy(state_q);
    assign vsync_fall = vsync_q && !vsync;

    hdcp_stall_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_stall (
        .clk   (clk),
        .rst   (rst),
        .en_i  (stall_en),
        .clr_i (stall_clr),
        .tc_o  (stall_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ri_out_q     <= '0;
            ri_update_q  <= 1'b0;
            frame_cnt_q  <= '0;
            enc_frame_q  <= 1'b0;
            authed_q     <= 1'b0;
            link_fault_q <= 1'b0;
            low_seen_q   <= 1'b0;
            pending_q    <= 1'b0;
            vsync_q      <= 1'b0;
        end else if (hpd) begin
            state_q      <= S_IDLE;
            ri_out_q     <= '0;
            ri_update_q  <= 1'b0;
            frame_cnt_q  <= '0;
            enc_frame_q  <= 1'b0;
            authed_q     <= 1'b0;
            link_fault_q <= 1'b0;
            low_seen_q   <= 1'b0;
            pending_q    <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            ri_update_q <= 1'b0;
            vsync_q     <= vsync;

            // Encryption decode sits ahead of the FSM so that restart and
            // fault handling below override it in the same cycle.
            if (authed_q) begin
                if (vsync) begin
                    if (ctl_code == CTL_ENC_EN)       pending_q <= 1'b1;
                    else if (ctl_code == CTL_ENC_DIS) pending_q <= 1'b0;
                end
                if (vsync_fall) enc_frame_q <= pending_q;
            end

            if (auth_start) begin
                // Restart beats frame_init and timeout; ri_out is kept.
                state_q     <= S_AUTH_BUSY;
                low_seen_q  <= 1'b0;
                authed_q    <= 1'b0;
                enc_frame_q <= 1'b0;
                pending_q   <= 1'b0;
                if (state_q == S_FAULT) link_fault_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_AUTH_BUSY, S_FRAME_BUSY: begin
                        if (stall_tc) begin
                            state_q      <= S_FAULT;
                            link_fault_q <= 1'b1;
                            authed_q     <= 1'b0;
                            enc_frame_q  <= 1'b0;
                        end else if (!stream_ready) begin
                            low_seen_q <= 1'b1;
                        end else if (low_seen_q) begin
                            low_seen_q <= 1'b0;
                            if (state_q == S_AUTH_BUSY) begin
                                state_q <= S_AUTH_DONE;
                            end else begin
                                state_q <= S_RUN;
                                if (frame_cnt_q == '0) begin
                                    ri_out_q    <= ri_in;
                                    ri_update_q <= 1'b1;
                                end
                            end
                        end
                    end
                    S_AUTH_DONE: begin
                        ri_out_q    <= ri_in;
                        ri_update_q <= 1'b1;
                        frame_cnt_q <= '0;
                        authed_q    <= 1'b1;
                        pending_q   <= 1'b0;
                        state_q     <= S_RUN;
                    end
                    S_RUN: begin
                        if (frame_init) begin
                            frame_cnt_q <= (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + 1'b1;
                            low_seen_q  <= 1'b0;
                            state_q     <= S_FRAME_BUSY;
                        end
                    end
                    S_FAULT: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ri_out     = ri_out_q;
    assign ri_update  = ri_update_q;
    assign frame_cnt  = frame_cnt_q;
    assign enc_frame  = enc_frame_q;
    assign authed     = authed_q;
    assign link_fault = link_fault_q;

endmodule

// File: tb/tb_hdcp_link_sequencer.sv
// tb_hdcp_link_sequencer
//   Randomized transaction-level bench. The reference model tracks the
//   link at frame/auth granularity (expected Ri, frame count, update
//   count, encryption flags) and is compared after each transaction.
module tb_hdcp_link_sequencer;
    localparam int RI_PERIOD   = 128;
    localparam int TIMEOUT_CYC = 4096;
    localparam int FCW         = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           hpd = 1'b0;
    logic           auth_start = 1'b0;
    logic           frame_init = 1'b0;
    logic           stream_ready = 1'b1;
    logic           vsync = 1'b0;
    logic [3:0]     ctl_code = 4'h0;
    logic [15:0]    ri_in = 16'h0;
    logic [15:0]    ri_out;
    logic           ri_update;
    logic [FCW-1:0] frame_cnt;
    logic           enc_frame;
    logic           authed;
    logic           link_fault;

    hdcp_link_sequencer #(.RI_PERIOD(RI_PERIOD), .TIMEOUT_CYC(TIMEOUT_CYC), .FCW(FCW)) dut (
        .clk(clk), .rst(rst), .hpd(hpd), .auth_start(auth_start), .frame_init(frame_init),
        .stream_ready(stream_ready), .vsync(vsync), .ctl_code(ctl_code), .ri_in(ri_in),
        .ri_out(ri_out), .ri_update(ri_update), .frame_cnt(frame_cnt), .enc_frame(enc_frame),
        .authed(authed), .link_fault(link_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    int m_ri = 0, m_cnt = 0, m_upd = 0;
    bit m_authed = 0, m_enc = 0, m_pend = 0;
    int upd_seen = 0;
    bit prev_upd = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ri_update) upd_seen++;
        chk("upd_pair", {31'b0, ri_update & prev_upd}, 32'd0);
        prev_upd = ri_update;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ri"},     ri_out,     m_ri);
        chk({tag, "_cnt"},    frame_cnt,  m_cnt);
        chk({tag, "_authed"}, authed,     m_authed);
        chk({tag, "_enc"},    enc_frame,  m_enc);
        chk({tag, "_fault"},  link_fault, 0);
        chk({tag, "_updcnt"}, upd_seen,   m_upd);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ri"},     ri_out,     0);
        chk({tag, "_upd"},    ri_update,  0);
        chk({tag, "_cnt"},    frame_cnt,  0);
        chk({tag, "_enc"},    enc_frame,  0);
        chk({tag, "_authed"}, authed,     0);
        chk({tag, "_fault"},  link_fault, 0);
    endtask

    task automatic model_clear();
        m_ri = 0; m_cnt = 0; m_authed = 0; m_enc = 0; m_pend = 0;
    endtask

    task automatic do_auth(input int lowcyc, input logic [15:0] ri, input bit with_fi);
        int n;
        auth_start = 1'b1; frame_init = with_fi;
        tick();
        auth_start = 1'b0; frame_init = 1'b0;
        m_authed = 0; m_enc = 0; m_pend = 0;
        chk("auth_authed0", authed, 0);
        chk("auth_enc0", enc_frame, 0);
        chk("auth_fault0", link_fault, 0);
        chk("auth_cnt_hold", frame_cnt, m_cnt);
        stream_ready = 1'b0; ri_in = 16'($urandom);
        repeat (lowcyc) tick();
        chk("auth_ri_hold", ri_out, m_ri);
        ri_in = ri; stream_ready = 1'b1;
        n = 0;
        while (!authed && n < 20) begin tick(); n++; end
        m_ri = ri; m_cnt = 0; m_upd++; m_authed = 1;
        check_all("auth");
    endtask

    task automatic do_frame(input int lowcyc, input logic [15:0] ri);
        frame_init = 1'b1;
        tick();
        m_cnt = (m_cnt + 1) % RI_PERIOD;
        chk("frm_cnt_inc", frame_cnt, m_cnt);
        // a second frame_init while busy must be ignored
        stream_ready = 1'b0; ri_in = 16'($urandom);
        tick();
        frame_init = 1'b0;
        repeat (lowcyc - 1) tick();
        ri_in = ri; stream_ready = 1'b1;
        tick();
        if (m_cnt == 0) begin m_ri = ri; m_upd++; end
        check_all("frm");
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // code < 0: random code each vsync-high cycle
    task automatic do_vsync(input int n, input int code);
        logic [3:0] c;
        vsync = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (code >= 0) c = 4'(code);
            else case ($urandom_range(0, 3))
                0: c = 4'b1001;
                1: c = 4'b0001;
                2: c = 4'b0101;
                default: c = 4'($urandom);
            endcase
            ctl_code = c;
            tick();
            if (m_authed) begin
                if (c == 4'b1001) m_pend = 1;
                else if (c == 4'b0001) m_pend = 0;
            end
            chk("vs_hold", enc_frame, m_enc);
        end
        vsync = 1'b0; ctl_code = 4'($urandom);
        tick();
        if (m_authed) m_enc = m_pend;
        chk("vs_enc", enc_frame, m_enc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset
        rst = 1'b1;
        repeat (3) tick();
        check_zero("rst");
        rst = 1'b0;
        tick();
        // frame_init in IDLE does nothing
        frame_init = 1'b1; tick(); frame_init = 1'b0; tick();
        chk("idle_fi_cnt", frame_cnt, 0);
        chk("idle_fi_authed", authed, 0);

        do_auth(10, 16'hA5C3, 0);

        // full Ri period: update only on the wrap frame
        for (int f = 1; f <= RI_PERIOD; f++)
            do_frame(5, (f == RI_PERIOD) ? 16'h1234 : 16'($urandom));
        chk("wrap_ri", ri_out, 16'h1234);

        // directed encryption decode
        do_vsync(2, 9);  chk("enc_on", enc_frame, 1);
        do_vsync(2, 1);  chk("enc_off", enc_frame, 0);
        do_vsync(1, 9);
        do_vsync(3, 5);  chk("enc_keep", enc_frame, 1);

        // random mix
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0, 1: do_frame($urandom_range(1, 8), 16'($urandom));
                2, 3: do_vsync($urandom_range(1, 3), -1);
                default: do_auth($urandom_range(1, 6), 16'($urandom), 1'($urandom));
            endcase
        end

        // auth_start coincident with frame_init in RUN
        do_frame(3, 16'($urandom));
        do_vsync(1, 9);
        do_auth(4, 16'($urandom), 1);

        // stall fault
        do_frame(2, 16'($urandom));
        do_vsync(1, 9);
        frame_init = 1'b1; tick(); frame_init = 1'b0;
        m_cnt = (m_cnt + 1) % RI_PERIOD;
        stream_ready = 1'b0;
        n = 0;
        while (!link_fault && n < TIMEOUT_CYC + 200) begin
            tick(); n++;
            if (n == TIMEOUT_CYC - 96) chk("fault_early", link_fault, 0);
        end
        chk("fault_set", link_fault, 1);
        chk("fault_lat", {31'b0, n >= TIMEOUT_CYC && n <= TIMEOUT_CYC + 4}, 1);
        chk("fault_authed", authed, 0);
        chk("fault_enc", enc_frame, 0);
        chk("fault_cnt", frame_cnt, m_cnt);
        m_authed = 0; m_enc = 0;
        repeat (5) tick();
        stream_ready = 1'b1;
        repeat (3) tick();
        chk("fault_sticky", link_fault, 1);
        do_auth(6, 16'($urandom), 0);

        // hpd mid frame
        do_frame(2, 16'($urandom));
        frame_init = 1'b1; tick(); frame_init = 1'b0;
        stream_ready = 1'b0; repeat (3) tick();
        hpd = 1'b1; tick(); hpd = 1'b0;
        check_zero("hpd");
        model_clear();
        stream_ready = 1'b1;
        frame_init = 1'b1; tick(); frame_init = 1'b0; tick();
        chk("hpd_idle_cnt", frame_cnt, 0);
        do_auth(3, 16'($urandom), 0);

        // async reset mid frame
        do_frame(2, 16'($urandom));
        frame_init = 1'b1; tick(); frame_init = 1'b0;
        stream_ready = 1'b0; tick();
        #2 rst = 1'b1;
        #1 check_zero("arst");
        tick();
        rst = 1'b0; stream_ready = 1'b1;
        model_clear();
        tick();
        check_zero("arst_rel");
        do_auth(5, 16'($urandom), 0);
        do_frame(3, 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
